// File: rtl/drive_pkg.sv
`default_nettype none
// ============================================================================
// Module      : drive_pkg
// Description : Shared definitions for the drive mode arbiter: state
//               encoding, driving-source indices, mode switch decode.
// Contents    : state_t, SRC_* indices, MODE_* switch codes, target_t,
//               decode_mode(), onehot3()
// Revision    : 1.0 - initial release
// ============================================================================
package drive_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_GRANT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic [1:0] SRC_MANUAL = 2'd0;
  localparam logic [1:0] SRC_SEMI   = 2'd1;
  localparam logic [1:0] SRC_AUTO   = 2'd2;

  localparam logic [1:0] MODE_HOLD   = 2'd0;
  localparam logic [1:0] MODE_SEMI   = 2'd1;
  localparam logic [1:0] MODE_AUTO   = 2'd2;
  localparam logic [1:0] MODE_MANUAL = 2'd3;

  // Decoded switch position: valid=0 means "no request, keep what we have".
  typedef struct packed {
    logic       valid;
    logic [1:0] src;
  } target_t;

  function automatic target_t decode_mode(input logic [1:0] sel);
    target_t t;
    t.valid = 1'b1;
    t.src   = SRC_MANUAL;
    case (sel)
      MODE_MANUAL: t.src = SRC_MANUAL;
      MODE_SEMI:   t.src = SRC_SEMI;
      MODE_AUTO:   t.src = SRC_AUTO;
      MODE_HOLD:   t.valid = 1'b0;
      default:     t.valid = 1'b0;
    endcase
    return t;
  endfunction

  // Index 3 is never a legal owner; it maps to an all-zero mask.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser followed by a stability filter. The
//               output level only moves after DEBOUNCE_CYCLES consecutive
//               synchronised samples that all disagree with it.
// Ports       : clk, rst (async, active-high), din (raw), level (filtered)
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // cnt holds how many disagreeing samples preceded this one; any agreeing
  // sample restarts the run. It never exceeds CNT_LAST, so it cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt >= CNT_LAST) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/drive_mode_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : drive_mode_arbiter
// Description : Owns the chassis outputs and grants them to one of three
//               driving sources (manual/semi/auto). Handles power on/off
//               from the power button and performs mode changes through a
//               brake (drain) and all-off (settle) handover.
// Ports       : clk, rst            - clock, async active-high reset
//               power_btn, mode_sel - raw button / mode switches
//               src_fwd/bwd/left/right/busy - per-source requests, bit i = src i
//               power_on, owner, src_en, switching, state - status outputs
//               move_forward/backward, turn_left/right   - chassis drive
// Revision    : 1.0 - initial release
// ============================================================================
module drive_mode_arbiter #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter int SETTLE_CYCLES   = 10000000,
  parameter int DRAIN_TIMEOUT   = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_btn,
  input  logic [1:0] mode_sel,
  input  logic [2:0] src_fwd,
  input  logic [2:0] src_bwd,
  input  logic [2:0] src_left,
  input  logic [2:0] src_right,
  input  logic [2:0] src_busy,
  output logic       power_on,
  output logic [1:0] owner,
  output logic [2:0] src_en,
  output logic       switching,
  output logic       move_forward,
  output logic       move_backward,
  output logic       turn_left,
  output logic       turn_right,
  output logic [1:0] state
);

  import drive_pkg::*;

  localparam int MAX_HS = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int MAX_DD = (DRAIN_TIMEOUT > DEBOUNCE_CYCLES) ? DRAIN_TIMEOUT : DEBOUNCE_CYCLES;
  localparam int MAX_P  = (MAX_HS > MAX_DD) ? MAX_HS : MAX_DD;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] HOLD_LIMIT  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // --------------------------------------------------------------------------
  // Input conditioning
  // --------------------------------------------------------------------------
  logic       pwr_db;
  logic       pwr_db_q;
  logic [1:0] mode_db;
  target_t    tgt;
  logic       pwr_rise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pwr_db (
    .clk(clk), .rst(rst), .din(power_btn), .level(pwr_db)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode1_db (
    .clk(clk), .rst(rst), .din(mode_sel[1]), .level(mode_db[1])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode0_db (
    .clk(clk), .rst(rst), .din(mode_sel[0]), .level(mode_db[0])
  );

  assign tgt      = decode_mode(mode_db);
  assign pwr_rise = pwr_db & ~pwr_db_q;

  // --------------------------------------------------------------------------
  // Timers and power-off arming
  // --------------------------------------------------------------------------
  logic             arm;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] drain_cnt;
  logic [CNT_W-1:0] settle_cnt;
  logic             hold_done;
  logic             drain_done;
  logic             settle_done;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] owner_q;
  logic [1:0] owner_d;

  // arm only sets once the button has been seen released while powered, so
  // the press that powered us on can never also power us off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr_db_q   <= 1'b0;
      arm        <= 1'b0;
      hold_cnt   <= '0;
      drain_cnt  <= '0;
      settle_cnt <= '0;
    end else begin
      pwr_db_q <= pwr_db;
      if (state_q == ST_OFF) begin
        arm      <= 1'b0;
        hold_cnt <= '0;
      end else begin
        if (!pwr_db) arm <= 1'b1;
        hold_cnt <= (arm && pwr_db) ? sat_inc(hold_cnt) : '0;
      end
      drain_cnt  <= (state_q == ST_DRAIN)  ? sat_inc(drain_cnt)  : '0;
      settle_cnt <= (state_q == ST_SETTLE) ? sat_inc(settle_cnt) : '0;
    end
  end

  assign hold_done   = hold_cnt >= HOLD_LIMIT;
  assign drain_done  = drain_cnt >= DRAIN_LAST;
  assign settle_done = settle_cnt >= SETTLE_LAST;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      owner_q <= SRC_MANUAL;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  logic busy_owner;
  assign busy_owner = |(src_busy & onehot3(owner_q));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (state_q != ST_OFF && hold_done) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (pwr_rise) begin
            state_d = ST_GRANT;
            owner_d = tgt.valid ? tgt.src : SRC_MANUAL;
          end
        end
        ST_GRANT: begin
          if (tgt.valid && tgt.src != owner_q) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!busy_owner || drain_done) state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          // Only the target seen at the end of the gap counts; "no request"
          // falls back to the previous owner.
          if (settle_done) begin
            state_d = ST_GRANT;
            if (tgt.valid) owner_d = tgt.src;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: output decode (from the next state, so registered outputs line up
  // with the state register)
  // --------------------------------------------------------------------------
  logic       power_on_d;
  logic [1:0] owner_out_d;
  logic [2:0] src_en_d;
  logic       switching_d;
  logic       fwd_d;
  logic       bwd_d;
  logic       left_d;
  logic       right_d;

  always_comb begin
    logic [2:0] sel;
    logic       f, b, l, r;
    sel         = onehot3(owner_d);
    f           = |(src_fwd & sel);
    b           = |(src_bwd & sel);
    l           = |(src_left & sel);
    r           = |(src_right & sel);
    power_on_d  = (state_d != ST_OFF);
    owner_out_d = power_on_d ? owner_d : 2'd0;
    src_en_d    = (state_d == ST_GRANT || state_d == ST_DRAIN) ? sel : 3'b000;
    switching_d = (state_d == ST_DRAIN || state_d == ST_SETTLE);
    fwd_d       = 1'b0;
    bwd_d       = 1'b0;
    left_d      = 1'b0;
    right_d     = 1'b0;
    if (state_d == ST_GRANT) begin
      // Opposing requests cancel rather than letting one side win.
      fwd_d   = f & ~b;
      bwd_d   = b & ~f;
      left_d  = l & ~r;
      right_d = r & ~l;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      power_on      <= 1'b0;
      owner         <= 2'd0;
      src_en        <= 3'b000;
      switching     <= 1'b0;
      move_forward  <= 1'b0;
      move_backward <= 1'b0;
      turn_left     <= 1'b0;
      turn_right    <= 1'b0;
    end else begin
      power_on      <= power_on_d;
      owner         <= owner_out_d;
      src_en        <= src_en_d;
      switching     <= switching_d;
      move_forward  <= fwd_d;
      move_backward <= bwd_d;
      turn_left     <= left_d;
      turn_right    <= right_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_drive_mode_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_drive_mode_arbiter
// Description : Scoreboard bench for drive_mode_arbiter. Each driven cycle
//               runs a reference model that predicts the outputs after the
//               following clock edge; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drive_mode_arbiter;

  localparam int DEB    = 4;
  localparam int HOLD   = 20;
  localparam int SETTLE = 8;
  localparam int DRAIN  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       power_btn = 1'b0;
  logic [1:0] mode_sel = 2'd3;
  logic [2:0] src_fwd = '0, src_bwd = '0, src_left = '0, src_right = '0, src_busy = '0;
  logic       power_on, switching, move_forward, move_backward, turn_left, turn_right;
  logic [1:0] owner, state;
  logic [2:0] src_en;

  always #5 clk = ~clk;

  drive_mode_arbiter #(
    .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE), .DRAIN_TIMEOUT(DRAIN)
  ) dut (
    .clk(clk), .rst(rst), .power_btn(power_btn), .mode_sel(mode_sel),
    .src_fwd(src_fwd), .src_bwd(src_bwd), .src_left(src_left), .src_right(src_right),
    .src_busy(src_busy), .power_on(power_on), .owner(owner), .src_en(src_en),
    .switching(switching), .move_forward(move_forward), .move_backward(move_backward),
    .turn_left(turn_left), .turn_right(turn_right), .state(state)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] own;
    logic       pon;
    logic [2:0] en;
    logic       sw;
    logic       f, b, l, r;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Stimulus intent, applied at the next falling edge.
  logic       drv_rst = 1'b1;
  logic       drv_btn = 1'b0;
  logic [1:0] drv_mode = 2'd3;
  bit         rnd = 1'b1;
  logic [2:0] fx_fwd = '0, fx_bwd = '0, fx_left = '0, fx_right = '0, fx_busy = '0;

  // ---------------------------------------------------------------- model
  // Edge count since reset, raw input history per edge, filtered levels,
  // and the edge at which the current phase began.
  int k = 0;
  bit pb_hist[$];
  bit m1_hist[$];
  bit m0_hist[$];
  bit pb_lvl = 0, m1_lvl = 0, m0_lvl = 0, pb_prev = 0;
  int ms = 0, mo = 0, tenter = 0, mhold = 0;
  bit marm = 0;

  // Synchronised sample seen at edge j is the raw value from two edges
  // earlier (zero for the first two edges after reset). The filtered level
  // flips once the last DEB samples all disagree with it.
  function automatic bit db_step(input bit hist[$], input bit lvl, input int kk);
    bit s;
    if (kk - DEB + 1 < 0) return lvl;
    for (int j = kk - DEB + 1; j <= kk; j++) begin
      s = (j >= 2) ? hist[j-2] : 1'b0;
      if (s == lvl) return lvl;
    end
    return !lvl;
  endfunction

  task automatic model_edge();
    obs_t e;
    int   ns, no, tgt;
    bit   tvalid, rise, f, b, l, r;
    if (drv_rst) begin
      k = 0; pb_hist.delete(); m1_hist.delete(); m0_hist.delete();
      pb_lvl = 0; m1_lvl = 0; m0_lvl = 0; pb_prev = 0;
      ms = 0; mo = 0; tenter = 0; mhold = 0; marm = 0;
      exp_q.push_back('0);
      return;
    end
    tvalid = 1'b1;
    case ({m1_lvl, m0_lvl})
      2'b11: tgt = 0;
      2'b01: tgt = 1;
      2'b10: tgt = 2;
      default: begin tgt = 0; tvalid = 1'b0; end
    endcase
    rise = pb_lvl && !pb_prev;
    ns = ms; no = mo;
    if (ms != 0 && mhold >= HOLD) ns = 0;
    else if (ms == 0) begin
      if (rise) begin ns = 1; no = tvalid ? tgt : 0; end
    end else if (ms == 1) begin
      if (tvalid && tgt != mo) ns = 2;
    end else if (ms == 2) begin
      if (!src_busy[mo] || (k - tenter) >= DRAIN) ns = 3;
    end else begin
      if ((k - tenter) >= SETTLE) begin ns = 1; if (tvalid) no = tgt; end
    end
    if (ns != ms) tenter = k;
    if (ms == 0) begin marm = 0; mhold = 0; end
    else begin
      mhold = (marm && pb_lvl) ? mhold + 1 : 0;
      if (!pb_lvl) marm = 1;
    end
    pb_hist.push_back(power_btn);
    m1_hist.push_back(mode_sel[1]);
    m0_hist.push_back(mode_sel[0]);
    pb_prev = pb_lvl;
    pb_lvl = db_step(pb_hist, pb_lvl, k);
    m1_lvl = db_step(m1_hist, m1_lvl, k);
    m0_lvl = db_step(m0_hist, m0_lvl, k);
    ms = ns; mo = no; k++;

    e = '0;
    e.st  = 2'(ns);
    e.own = (ns == 0) ? 2'd0 : 2'(no);
    e.pon = (ns != 0);
    e.en  = (ns == 1 || ns == 2) ? 3'(1 << no) : 3'b000;
    e.sw  = (ns == 2 || ns == 3);
    if (ns == 1) begin
      f = src_fwd[no]; b = src_bwd[no]; l = src_left[no]; r = src_right[no];
      e.f = f && !b; e.b = b && !f; e.l = l && !r; e.r = r && !l;
    end
    exp_q.push_back(e);
  endtask

  // ------------------------------------------------------------- stimulus
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst       = drv_rst;
      power_btn = drv_btn;
      mode_sel  = drv_mode;
      if (rnd) begin
        src_fwd = 3'($urandom); src_bwd = 3'($urandom); src_left = 3'($urandom);
        src_right = 3'($urandom); src_busy = 3'($urandom);
      end else begin
        src_fwd = fx_fwd; src_bwd = fx_bwd; src_left = fx_left;
        src_right = fx_right; src_busy = fx_busy;
      end
      model_edge();
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // -------------------------------------------------------------- monitor
  always @(posedge clk) begin
    obs_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, owner, power_on, src_en, switching,
           move_forward, move_backward, turn_left, turn_right};
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL scoreboard: got st=%0d own=%0d pon=%0b en=%b sw=%0b fblr=%b%b%b%b, expected st=%0d own=%0d pon=%0b en=%b sw=%0b fblr=%b%b%b%b (t=%0t)",
                 a.st, a.own, a.pon, a.en, a.sw, a.f, a.b, a.l, a.r,
                 e.st, e.own, e.pon, e.en, e.sw, e.f, e.b, e.l, e.r, $time);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset
    cyc(3);
    chk("reset_outputs", 32'({state, owner, power_on, src_en, switching,
        move_forward, move_backward, turn_left, turn_right}), 32'd0);
    drv_rst = 1'b0;
    cyc(8);

    // Power on with manual selected; keep holding without release.
    drv_btn = 1'b1;
    cyc(10);
    chk("pon_state", 32'(state), 32'd1);
    chk("pon_owner", 32'(owner), 32'd0);
    chk("pon_src_en", 32'(src_en), 32'b001);
    chk("pon_power", 32'(power_on), 32'd1);
    cyc(30);
    chk("held_no_off", 32'(state), 32'd1);
    drv_btn = 1'b0;
    cyc(10);

    // Forwarding and conflict masking
    rnd = 1'b0;
    fx_fwd = 3'b001; fx_left = 3'b001; fx_bwd = 3'b010; fx_right = 3'b010; fx_busy = 3'b000;
    cyc(2);
    chk("fwd_forward", 32'(move_forward), 32'd1);
    chk("fwd_left", 32'(turn_left), 32'd1);
    chk("fwd_src1_ignored", 32'({move_backward, turn_right}), 32'd0);
    fx_bwd = 3'b001; fx_right = 3'b001;
    cyc(2);
    chk("conflict_masked", 32'({move_forward, move_backward, turn_left, turn_right}), 32'd0);
    rnd = 1'b1;
    cyc(20);

    // Handover 0 -> 2 with busy dropping during drain
    rnd = 1'b0;
    fx_fwd = '0; fx_bwd = '0; fx_left = '0; fx_right = '0; fx_busy = 3'b001;
    drv_mode = 2'd2;
    cyc(11);
    chk("drain_state", 32'(state), 32'd2);
    chk("drain_src_en", 32'(src_en), 32'b001);
    chk("drain_switching", 32'(switching), 32'd1);
    fx_busy = 3'b000;
    cyc(5);
    chk("settle_state", 32'(state), 32'd3);
    chk("settle_src_en", 32'(src_en), 32'b000);
    cyc(10);
    chk("handover_owner", 32'(owner), 32'd2);
    chk("handover_src_en", 32'(src_en), 32'b100);

    // Drain timeout with busy stuck
    fx_busy = 3'b111;
    drv_mode = 2'd1;
    cyc(15);
    chk("timeout_in_drain", 32'(state), 32'd2);
    cyc(10);
    chk("timeout_in_settle", 32'(state), 32'd3);
    cyc(10);
    chk("timeout_owner", 32'(owner), 32'd1);

    // Short glitches on the button
    rnd = 1'b1;
    for (int g = 0; g < 3; g++) begin
      drv_btn = 1'b1; cyc(3);
      drv_btn = 1'b0; cyc(5);
    end
    chk("glitch_no_change", 32'({state, power_on}), 32'b011);

    // Power-off hold during a drain
    rnd = 1'b0; fx_busy = 3'b111;
    drv_btn = 1'b1;
    cyc(8);
    drv_mode = 2'd3;
    cyc(14);
    chk("poff_in_drain", 32'(state), 32'd2);
    cyc(8);
    chk("poff_state", 32'(state), 32'd0);
    chk("poff_outputs", 32'({power_on, src_en}), 32'd0);
    drv_btn = 1'b0;
    cyc(10);

    // Power back on, start a handover, reset in the middle of settle
    drv_btn = 1'b1; cyc(10);
    drv_btn = 1'b0; cyc(8);
    fx_busy = 3'b000;
    drv_mode = 2'd2;
    w = 0;
    while (state != 2'd3 && w < 30) begin cyc(1); w++; end
    chk("reach_settle", 32'(state), 32'd3);
    cyc(2);
    drv_rst = 1'b1;
    cyc(1);
    #1;
    chk("async_reset", 32'({state, owner, power_on, src_en, switching,
        move_forward, move_backward, turn_left, turn_right}), 32'd0);
    cyc(2);
    drv_rst = 1'b0;
    drv_mode = 2'd1;
    cyc(8);
    drv_btn = 1'b1; cyc(10);
    chk("repower_state", 32'(state), 32'd1);
    chk("repower_owner", 32'(owner), 32'd1);
    drv_btn = 1'b0; cyc(6);

    // Randomised mode/button activity
    rnd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drv_mode = 2'($urandom);
      drv_btn  = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 28));
    end
    drv_btn = 1'b0;
    cyc(3);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
